// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : secded_pkg
//  Description : Shared SECDED Hamming helpers. The encoder and decoder both
//                use it for codeword geometry: parity width, codeword width
//                and the position map of the data bits.
//  Revision    : 1.0  initial streaming-encoder release
// ============================================================================
package secded_pkg;

   localparam int MIN_DATA_W = 4;
   localparam int MAX_DATA_W = 57;

   // Smallest r such that 2^r >= data_w + r + 1
   function automatic int par_w(input int data_w);
      int r;
      r = 1;
      while ((1 << r) < (data_w + r + 1)) r++;
      return r;
   endfunction

   // Data bits + Hamming parity bits + overall parity bit
   function automatic int code_w(input int data_w);
      return data_w + par_w(data_w) + 1;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Codeword position of data bit i: the i-th position (ascending from 3)
   // that is neither 0 nor a power of two.
   function automatic int data_pos(input int i);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int p = 3; p < 128; p++) begin
         if (!is_pow2(p)) begin
            if (cnt == i) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage
`default_nettype wire

// File: rtl/secded_pos_xor.sv
`default_nettype none
// ============================================================================
//  Module      : secded_pos_xor
//  Description : Combinational XOR of the indices of all set bits in a
//                vector. Produces the Hamming parity word on the encode side
//                and the syndrome on the decode side.
//  Revision    : 1.0  initial release
// ============================================================================
module secded_pos_xor #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] posXor
);

   // Fold the index of every set bit into the accumulator
   always_comb begin
      posXor = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) posXor = posXor ^ IDX_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/secded_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : secded_encoder
//  Description : Streaming SECDED Hamming encoder with a two-stage
//                valid/ready pipeline. Stage 1 holds the data word and its
//                Hamming parity word; stage 2 holds the assembled codeword
//                with overall even parity in bit 0.
//                Optional macro SECDED_ENC_ERR_INJECT_EN adds inj_en/inj_mask
//                ports that XOR a mask onto the finished codeword.
//  Revision    : 1.0  initial streaming release
// ============================================================================
module secded_encoder
   import secded_pkg::*;
#(
   parameter  int DATA_W = 11,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CODE_W = code_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code
`ifdef SECDED_ENC_ERR_INJECT_EN
   ,
   input  logic              inj_en,
   input  logic [CODE_W-1:0] inj_mask
`endif
);

   if ((DATA_W < MIN_DATA_W) || (DATA_W > MAX_DATA_W)) begin : g_badDataW
      $error("secded_encoder: DATA_W=%0d outside supported range %0d..%0d",
             DATA_W, MIN_DATA_W, MAX_DATA_W);
   end

   logic              r_s1Valid;
   logic [DATA_W-1:0] r_s1Data;
   logic [PAR_W-1:0]  r_s1Par;
   logic              r_s2Valid;
   logic [CODE_W-1:0] r_s2Code;

   logic [CODE_W-1:0] w_inVec;   // input data scattered to codeword positions
   logic [PAR_W-1:0]  w_parWord;
   logic [CODE_W-1:1] w_body;    // stage-1 word assembled, positions 1..CODE_W-1
   logic [CODE_W-1:0] w_code;
   logic [CODE_W-1:0] w_final;
   logic              w_s1Load;
   logic              w_s2Load;

   // Scatter data bits to their positions; parity and overall slots stay zero
   assign w_inVec[0] = 1'b0;
   for (genvar i = 0; i < DATA_W; i++) begin : g_dataMap
      localparam int c_POS = data_pos(i);
      assign w_inVec[c_POS] = in_data[i];
      assign w_body[c_POS]  = r_s1Data[i];
   end
   for (genvar k = 0; k < PAR_W; k++) begin : g_parMap
      localparam int c_PPOS = 1 << k;
      assign w_inVec[c_PPOS] = 1'b0;
      assign w_body[c_PPOS]  = r_s1Par[k];
   end

   secded_pos_xor #(
      .WIDTH (CODE_W),
      .IDX_W (PAR_W)
   ) u_posXor (
      .vec    (w_inVec),
      .posXor (w_parWord)
   );

   // Overall parity makes the whole codeword even
   assign w_code = {w_body, ^w_body};

`ifdef SECDED_ENC_ERR_INJECT_EN
   logic [CODE_W-1:0] r_s1Mask;   // effective mask: zero unless inj_en was set
   assign w_final = w_code ^ r_s1Mask;
`else
   assign w_final = w_code;
`endif

   // A stage loads when it is empty or the stage behind it is draining.
   // No handshake is offered while rst is high.
   assign w_s2Load = !r_s2Valid || out_ready;
   assign w_s1Load = !r_s1Valid || w_s2Load;
   assign in_ready = !rst && w_s1Load;

   // Stage 1: capture data word and Hamming parity word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_s1Data  <= '0;
         r_s1Par   <= '0;
`ifdef SECDED_ENC_ERR_INJECT_EN
         r_s1Mask  <= '0;
`endif
      end else if (w_s1Load) begin
         r_s1Valid <= in_valid;
         if (in_valid) begin
            r_s1Data <= in_data;
            r_s1Par  <= w_parWord;
`ifdef SECDED_ENC_ERR_INJECT_EN
            r_s1Mask <= inj_en ? inj_mask : '0;
`endif
         end
      end
   end

   // Stage 2: capture the fully assembled codeword; holds while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2Valid <= 1'b0;
         r_s2Code  <= '0;
      end else if (w_s2Load) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) r_s2Code <= w_final;
      end
   end

   assign out_valid = r_s2Valid;
   assign out_code  = r_s2Code;

endmodule
`default_nettype wire

// File: tb/tb_secded_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_secded_encoder
//  Description : Self-checking bench for secded_encoder (DATA_W=11 and 4).
//                Expected codewords are queued at input acceptance and
//                compared by independent output monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_secded_encoder;

   typedef struct {
      logic [63:0] code;
      int          data;
      int          acc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_code;
   logic        inj_en = 1'b0;
   logic [15:0] inj_mask = '0;

   logic        in4_valid = 1'b0;
   logic        in4_ready;
   logic [3:0]  in4_data = '0;
   logic        out4_valid;
   logic        out4_ready = 1'b1;
   logic [7:0]  out4_code;

   exp_t q[$];
   exp_t q4[$];
   int   errors = 0;
   int   nChecks = 0;
   int   cyc = 0;
   bit   rndReady = 1'b0;
   bit   readyCmd = 1'b1;
   logic [15:0] obs [0:2047];
   bit          obsSeen [0:2047];

   always #5 clk = ~clk;

   secded_encoder #(.DATA_W(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code)
`ifdef SECDED_ENC_ERR_INJECT_EN
      ,
      .inj_en    (inj_en),
      .inj_mask  (inj_mask)
`endif
   );

   secded_encoder #(.DATA_W(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in4_valid),
      .in_ready  (in4_ready),
      .in_data   (in4_data),
      .out_valid (out4_valid),
      .out_ready (out4_ready),
      .out_code  (out4_code)
`ifdef SECDED_ENC_ERR_INJECT_EN
      ,
      .inj_en    (1'b0),
      .inj_mask  (8'h00)
`endif
   );

   // Reference: walk codeword positions, place data bits in non-power-of-two
   // slots, XOR the positions of ones, then set parity and overall parity.
   function automatic logic [63:0] ref_code(input int dw, input logic [63:0] d);
      int pw;
      int cw;
      int k;
      int syn;
      logic [63:0] c;
      pw = 1;
      while ((1 << pw) < dw + pw + 1) pw++;
      cw  = dw + pw + 1;
      c   = '0;
      k   = 0;
      syn = 0;
      for (int p = 1; p < cw; p++) begin
         if ((p & (p - 1)) != 0) begin
            c[p] = d[k];
            if (d[k]) syn = syn ^ p;
            k++;
         end
      end
      for (int b = 0; b < pw; b++) c[1 << b] = syn[b];
      c[0] = ^c;
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sink ready driver (runs after the main process drives at +1)
   initial forever begin
      @(posedge clk);
      #2;
      out_ready = rndReady ? ($urandom_range(0, 3) != 0) : readyCmd;
   end

   // Monitor for the 11-bit encoder
   initial begin : mon11
      bit          holdPend;
      logic [15:0] holdCode;
      exp_t        e;
      holdPend = 1'b0;
      holdCode = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            holdPend = 1'b0;
         end else begin
            if (holdPend) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_code", 64'(out_code), 64'(holdCode));
            end
            holdPend = out_valid && !out_ready;
            holdCode = out_code;
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_output", 64'(out_code), 64'hDEAD_0000_0000_0000);
               end else begin
                  e = q.pop_front();
                  chk("code", 64'(out_code), e.code);
                  chk("even_weight", 64'($countones(out_code) % 2), 64'd0);
                  if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
                  if (e.data >= 0 && e.data < 2048) begin
                     obs[e.data]     = out_code;
                     obsSeen[e.data] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Monitor for the 4-bit encoder
   initial begin : mon4
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out4_valid && out4_ready) begin
            if (q4.size() == 0) begin
               chk("unexpected_output4", 64'(out4_code), 64'hDEAD_0000_0000_0000);
            end else begin
               e = q4.pop_front();
               chk("code4", 64'(out4_code), e.code);
            end
         end
      end
   end

   task automatic send(input int d, input logic [63:0] expCode, input bit lat,
                       input bit en, input logic [15:0] m);
      bit   done;
      exp_t e;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = 11'(d);
`ifdef SECDED_ENC_ERR_INJECT_EN
      inj_en   = en;
      inj_mask = m;
`endif
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.code = expCode;
            e.data = d;
            e.acc  = cyc;
            e.lat  = lat;
            q.push_back(e);
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         chk("accept_timeout", 64'(done), 64'd1);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send4(input int d, input logic [63:0] expCode);
      bit   done;
      exp_t e;
      done      = 1'b0;
      in4_valid = 1'b1;
      in4_data  = 4'(d);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (in4_ready) begin
            e.code = expCode;
            e.data = -1;
            e.acc  = cyc;
            e.lat  = 1'b0;
            q4.push_back(e);
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         chk("accept4_timeout", 64'(done), 64'd1);
      end else begin
         @(posedge clk);
         #1;
      end
      in4_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 1000 && (q.size() != 0 || q4.size() != 0); t++) @(posedge clk);
      #1;
      chk("drain_pending", 64'(q.size() + q4.size()), 64'd0);
   endtask

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          d;
      int          a;
      int          b;
      int          minD;
      int          missing;
      logic [63:0] r;
      exp_t        e;

      for (int i = 0; i < 2048; i++) obsSeen[i] = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_code", 64'(out_code), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out4_valid", 64'(out4_valid), 64'd0);
      @(posedge clk);
      #1;

      // Known vectors, back to back, no backpressure
      send(11'h000, 64'h0000, 1'b1, 1'b0, 16'h0);
      send(11'h001, 64'h000F, 1'b1, 1'b0, 16'h0);
      send(11'h42D, 64'h84DE, 1'b1, 1'b0, 16'h0);
      send(11'h7FF, 64'hFFFF, 1'b1, 1'b0, 16'h0);
      drain();

      // Smallest configuration
      send4(4'hF, 64'hFF);
      send4(4'h1, 64'h0F);
      for (int i = 0; i < 8; i++) begin
         d = int'($urandom_range(0, 15));
         send4(d, ref_code(4, 64'(d)));
      end
      drain();

      // All 2048 inputs with random idle cycles and random sink stalls
      rndReady = 1'b1;
      for (int v = 0; v < 2048; v++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send(v, ref_code(11, 64'(v)), 1'b0, 1'b0, 16'h0);
      end
      drain();
      rndReady = 1'b0;
      readyCmd = 1'b1;
      @(posedge clk);
      #1;

      missing = 0;
      for (int i = 0; i < 2048; i++) if (!obsSeen[i]) missing++;
      chk("exhaustive_missing", 64'(missing), 64'd0);
      minD = 99;
      for (int i = 0; i < 4000; i++) begin
         a = int'($urandom_range(0, 2047));
         b = int'($urandom_range(0, 2047));
         if (a != b && $countones(obs[a] ^ obs[b]) < minD) minD = $countones(obs[a] ^ obs[b]);
      end
      chk("min_distance_ge4", 64'(minD >= 4), 64'd1);

      // Backpressure: two accepts fill the pipe, third waits for release
      readyCmd = 1'b0;
      @(posedge clk);
      #1;
      send(11'h123, ref_code(11, 64'h123), 1'b0, 1'b0, 16'h0);
      send(11'h456, ref_code(11, 64'h456), 1'b0, 1'b0, 16'h0);
      in_valid = 1'b1;
      in_data  = 11'h789;
      repeat (3) begin
         @(negedge clk);
         chk("full_in_ready", 64'(in_ready), 64'd0);
         chk("full_out_valid", 64'(out_valid), 64'd1);
         @(posedge clk);
         #1;
      end
      readyCmd = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) begin
         r      = ref_code(11, 64'h789);
         e.code = r;
         e.data = 11'h789;
         e.acc  = cyc;
         e.lat  = 1'b0;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Mid-stream reset discards two in-flight words
      readyCmd = 1'b0;
      @(posedge clk);
      #1;
      send(11'h0AA, 64'h0, 1'b0, 1'b0, 16'h0);
      send(11'h155, 64'h0, 1'b0, 1'b0, 16'h0);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_out_code", 64'(out_code), 64'd0);
      @(posedge clk);
      #1 readyCmd = 1'b1;
      @(posedge clk);
      #1;
      send(11'h3C5, ref_code(11, 64'h3C5), 1'b1, 1'b0, 16'h0);
      drain();

`ifdef SECDED_ENC_ERR_INJECT_EN
      send(11'h42D, 64'h84DD, 1'b1, 1'b1, 16'h0003);
      send(11'h42D, 64'h84DE, 1'b1, 1'b0, 16'h0003);
      drain();
`endif

      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
